pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central control that drives the stall[5:0]/flush/new_pc side of every pipeline register.
//  - Prioritises stall requests from ID, EX and MEM.
//  - Turns the exception code from MEM into a flush pulse and a redirect PC.
//  - Holds the flush for a fixed number of cycles.
//  - Sits beside the core; its outputs fan out to pc_reg, if_id, id_ex, ex_mem and mem_wb.
// PARAMETERS
//  FLUSH_CYCLES   1             cycles flush stays high per exception (>=1)
//  EXC_VECTOR     32'hBFC00380  redirect PC for all non-ERET exceptions
//  STALL_TIMEOUT  1024          consecutive stall cycles before watchdog trips (watchdog build only)
// PORTS
//  clk              in   1   core clock, all state on posedge
//  rst              in   1   synchronous reset, active-low (rst==0 resets on posedge clk)
//  stallreq_id_i    in   1   ID load-use / branch hazard request
//  stallreq_ex_i    in   1   EX multi-cycle (mul/div) request
//  stallreq_mem_i   in   1   MEM bus/cache-miss request
//  excepttype_i     in   32  final exception code from MEM; 0 = none
//  cp0_epc_i        in   32  current CP0 EPC, used for ERET
//  stall            out  6   [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold
//  flush            out  1   clears all pipeline registers
//  new_pc           out  32  redirect target, valid while flush==1
//  stall_timeout_o  out  1   watchdog trip, sticky (watchdog build only)
// BEHAVIOUR
//  Reset values and reset mid-operation
//   - Reset: stall=6'b0, flush=0, new_pc=32'h0, stall_timeout_o=0.
//   - FSM returns to IDLE and hold counter clears, even mid-HOLD.
//  FSM: IDLE, HOLD
//   IDLE, excepttype_i != 0
//    - flush=1 combinationally in the same cycle; stall=6'b0 (flush overrides all stall requests).
//    - new_pc = cp0_epc_i if excepttype_i==32'h0000000e (ERET); otherwise EXC_VECTOR.
//    - On the same posedge, new_pc is latched into an internal register.
//    - If FLUSH_CYCLES>1: go to HOLD with cnt=FLUSH_CYCLES-1.
//   IDLE, excepttype_i == 0
//    - flush=0, new_pc=32'h0.
//    - stall is combinational from requests, highest priority first:
//      - mem req -> 6'b011111
//      - else ex req -> 6'b001111
//      - else id req -> 6'b000111
//      - else 6'b000000
//    - The id case (stall[2]=1, stall[3]=0) makes id_ex insert a bubble.
//   HOLD
//    - flush=1, new_pc=latched value, stall=6'b0.
//    - excepttype_i and stall requests are ignored; cnt decrements each cycle.
//    - cnt==1 -> IDLE next cycle.
//   Latency
//    - Exception in cycle N: flush high in cycles N..N+FLUSH_CYCLES-1, low at N+FLUSH_CYCLES.
//    - A new exception is only accepted once back in IDLE.
//  Simultaneous events
//   - Exception + any stall request: flush wins, stall=0.
//   - mem+ex+id requests together: 6'b011111.
//  Width rules
//   - cnt is $clog2(FLUSH_CYCLES+1) bits; no wrap (it saturates at the HOLD exit).
// CONFIGURATION
//  PIPELINE_CTRL_WATCHDOG_EN defined
//   - A 16-bit counter increments each cycle stall!=0 while in IDLE; it clears when stall==0 or flush==1.
//   - When the counter reaches STALL_TIMEOUT, stall_timeout_o sets to 1 and stays set until reset.
//   - The counter saturates at STALL_TIMEOUT.
//   - Stall behaviour is unchanged.
//  PIPELINE_CTRL_WATCHDOG_EN undefined
//   - No counter; stall_timeout_o is tied to 0.
// TESTING
//  T1 reset: rst=0 two cycles with all requests=1, excepttype_i=8 -> stall=0, flush=0, new_pc=0 after posedge.
//  T2 priority: id=1 -> 000111; id=1,ex=1 -> 001111; all three=1 -> 011111; all 0 -> 000000, same cycle.
//  T3 syscall: excepttype_i=32'h8 with mem req=1 -> same cycle flush=1, stall=0, new_pc=32'hBFC00380; next cycle flush=0 (FLUSH_CYCLES=1).
//  T4 eret hold: FLUSH_CYCLES=3, cp0_epc_i=32'h80001000, excepttype_i=32'he for one cycle, then epc changed -> flush=1 three cycles, new_pc=32'h80001000 throughout, stall=0.
//  T5 reset in HOLD: FLUSH_CYCLES=4, exception, rst=0 on cycle 2 -> next cycle flush=0, FSM IDLE, requests honoured immediately after rst=1.
//  T6 watchdog: STALL_TIMEOUT=8, ex req held 8 cycles -> stall_timeout_o=1 after 8th stall cycle, stays 1 after request drops; without macro stays 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: prioritises hazard stalls and turns MEM exceptions into a timed flush with redirect PC.
// Optional stall watchdog is built when PIPELINE_CTRL_WATCHDOG_EN is defined.
//
// state | meaning
// IDLE  | normal operation; stalls follow requests, an exception starts a flush
// HOLD  | flush extended past the first cycle; inputs ignored until cnt reaches 1
module pipeline_ctrl #(
   parameter int          FLUSH_CYCLES  = 1,
   parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
   parameter int          STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout_o
);

   localparam int                CNT_W     = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
   localparam logic [31:0]       ERET_CODE = 32'h0000000e;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       pc_hold, pc_hold_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         pc_hold <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pc_hold <= pc_hold_nxt;
      end
   end

   // Outputs are forced quiet while reset is asserted, even with requests pending.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_hold_nxt = pc_hold;
      stall       = 6'b000000;
      flush       = 1'b0;
      new_pc      = 32'h0;
      if (rst) begin
         case (state)
            IDLE: begin
               if (excepttype_i != 32'h0) begin
                  flush       = 1'b1;
                  new_pc      = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                  pc_hold_nxt = new_pc;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = HOLD;
                     cnt_nxt   = CNT_LOAD;
                  end
               end else if (stallreq_mem_i) begin
                  stall = 6'b011111;
               end else if (stallreq_ex_i) begin
                  stall = 6'b001111;
               end else if (stallreq_id_i) begin
                  stall = 6'b000111;
               end
            end
            HOLD: begin
               flush   = 1'b1;
               new_pc  = pc_hold;
               cnt_nxt = cnt - 1'b1;
               if (cnt == CNT_LAST) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef PIPELINE_CTRL_WATCHDOG_EN
   localparam logic [15:0] WD_LIMIT = 16'(STALL_TIMEOUT);

   logic [15:0] wd_cnt, wd_cnt_nxt;
   logic        wd_trip;

   always_comb begin
      wd_cnt_nxt = wd_cnt;
      if (flush || (stall == 6'b000000) || (state != IDLE)) begin
         wd_cnt_nxt = 16'h0;
      end else if (wd_cnt != WD_LIMIT) begin
         wd_cnt_nxt = wd_cnt + 16'h1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_cnt  <= 16'h0;
         wd_trip <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt_nxt;
         if (wd_cnt_nxt == WD_LIMIT) begin
            wd_trip <= 1'b1;
         end
      end
   end

   assign stall_timeout_o = wd_trip;
`else
   assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (1-cycle and 3-cycle flush) share stimulus;
// a cycle-level reference model queues expected outputs and a negedge monitor compares them.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif
   localparam int          TIMEOUT = 8;
   localparam logic [31:0] VEC     = 32'hBFC00380;

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0, stallreq_mem_i = 1'b0;
   logic [31:0] excepttype_i = 32'h0, cp0_epc_i = 32'h0;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b, to_a, to_b;
   logic [31:0] pc_a, pc_b;

   exp_t q_a[$];
   exp_t q_b[$];

   int   vectors = 0;
   int   miscompares = 0;

   int          busy[2] = '{0, 0};
   logic [31:0] held[2] = '{32'h0, 32'h0};
   int          run[2]  = '{0, 0};
   bit          trip[2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   pipeline_ctrl #(.FLUSH_CYCLES(1), .EXC_VECTOR(VEC), .STALL_TIMEOUT(TIMEOUT)) dut_a (
      .clk(clk), .rst(rst),
      .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .stall_timeout_o(to_a)
   );

   pipeline_ctrl #(.FLUSH_CYCLES(3), .EXC_VECTOR(VEC), .STALL_TIMEOUT(TIMEOUT)) dut_b (
      .clk(clk), .rst(rst),
      .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .stall_timeout_o(to_b)
   );

   // Expected response for the current cycle, then advance the model across the coming edge.
   task automatic model(input int d);
      exp_t e;
      int   fc;
      fc = (d == 0) ? 1 : 3;
      e  = '0;
      if (!rst) begin
         e = '0;
      end else if (busy[d] > 0) begin
         e.flush = 1'b1;
         e.pc    = held[d];
      end else if (excepttype_i != 32'h0) begin
         e.flush = 1'b1;
         e.pc    = (excepttype_i == 32'he) ? cp0_epc_i : VEC;
      end else if (stallreq_mem_i) begin
         e.stall = 6'b011111;
      end else if (stallreq_ex_i) begin
         e.stall = 6'b001111;
      end else if (stallreq_id_i) begin
         e.stall = 6'b000111;
      end
      e.to = WD_ON ? trip[d] : 1'b0;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);

      if (!rst) begin
         busy[d] = 0;
         run[d]  = 0;
         trip[d] = 1'b0;
      end else begin
         if (busy[d] > 0) begin
            busy[d] = busy[d] - 1;
         end else if (excepttype_i != 32'h0) begin
            held[d] = e.pc;
            busy[d] = fc - 1;
         end
         if (e.flush || e.stall == 6'b0) begin
            run[d] = 0;
         end else begin
            if (run[d] < TIMEOUT) run[d] = run[d] + 1;
            if (run[d] == TIMEOUT) trip[d] = 1'b1;
         end
      end
   endtask

   task automatic cycle(input logic r, input logic [2:0] req, input logic [31:0] code, input logic [31:0] epc);
      @(posedge clk);
      #1;
      rst = r;
      {stallreq_mem_i, stallreq_ex_i, stallreq_id_i} = req;
      excepttype_i = code;
      cp0_epc_i    = epc;
      model(0);
      model(1);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         vectors++;
         cmp("fc1.stall", {26'h0, stall_a}, {26'h0, e.stall});
         cmp("fc1.flush", {31'h0, flush_a}, {31'h0, e.flush});
         cmp("fc1.new_pc", pc_a, e.pc);
         cmp("fc1.timeout", {31'h0, to_a}, {31'h0, e.to});
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         vectors++;
         cmp("fc3.stall", {26'h0, stall_b}, {26'h0, e.stall});
         cmp("fc3.flush", {31'h0, flush_b}, {31'h0, e.flush});
         cmp("fc3.new_pc", pc_b, e.pc);
         cmp("fc3.timeout", {31'h0, to_b}, {31'h0, e.to});
      end
   end

   initial begin
      logic [2:0]  req;
      logic [31:0] code;
      // reset held with everything asserted
      cycle(1'b0, 3'b111, 32'h8, 32'h0);
      cycle(1'b0, 3'b111, 32'h8, 32'h0);
      // priority encoding
      cycle(1'b1, 3'b001, 32'h0, 32'h0);
      cycle(1'b1, 3'b011, 32'h0, 32'h0);
      cycle(1'b1, 3'b111, 32'h0, 32'h0);
      cycle(1'b1, 3'b000, 32'h0, 32'h0);
      cycle(1'b1, 3'b100, 32'h0, 32'h0);
      cycle(1'b1, 3'b010, 32'h0, 32'h0);
      cycle(1'b1, 3'b101, 32'h0, 32'h0);
      // syscall with mem stall pending
      cycle(1'b1, 3'b100, 32'h8, 32'h0);
      repeat (3) cycle(1'b1, 3'b000, 32'h0, 32'h0);
      // eret, epc changes afterwards, requests and new exceptions during hold
      cycle(1'b1, 3'b000, 32'he, 32'h80001000);
      cycle(1'b1, 3'b111, 32'h8, 32'h12345678);
      cycle(1'b1, 3'b010, 32'he, 32'h12345678);
      cycle(1'b1, 3'b001, 32'h0, 32'h12345678);
      cycle(1'b1, 3'b000, 32'h0, 32'h0);
      // reset in the middle of a hold
      cycle(1'b1, 3'b000, 32'h8, 32'h0);
      cycle(1'b0, 3'b111, 32'h0, 32'h0);
      cycle(1'b1, 3'b001, 32'h0, 32'h0);
      cycle(1'b1, 3'b000, 32'h0, 32'h0);
      // watchdog: ex request held past the limit, then dropped
      repeat (10) cycle(1'b1, 3'b010, 32'h0, 32'h0);
      repeat (3) cycle(1'b1, 3'b000, 32'h0, 32'h0);
      cycle(1'b0, 3'b000, 32'h0, 32'h0);
      cycle(1'b1, 3'b000, 32'h0, 32'h0);
      // seven-cycle run stays below the limit, an exception breaks a run
      repeat (7) cycle(1'b1, 3'b001, 32'h0, 32'h0);
      cycle(1'b1, 3'b000, 32'h0, 32'h0);
      repeat (5) cycle(1'b1, 3'b100, 32'h0, 32'h0);
      cycle(1'b1, 3'b100, 32'he, 32'hA0000040);
      repeat (5) cycle(1'b1, 3'b100, 32'h0, 32'h0);
      // randomized traffic with sticky request phases
      req = 3'b000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) req = 3'($urandom_range(0, 7));
         code = 32'h0;
         if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 2))
               0:       code = 32'h8;
               1:       code = 32'he;
               default: code = $urandom | 32'h1;
            endcase
         end
         cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, req, code, $urandom);
      end
      for (int i = 0; i < 5 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (q_a.size() > 0 || q_b.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d expected responses left unchecked, required 0", q_a.size(), q_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
